display_scanner: RTL and testbench

Time-multiplexing scan controller for the 8-digit seven-segment display. It generates the 3-bit digit index that drives the nibble selector and the active-low anode enables. It latches a frame-consistent copy of the 32-bit display word for the selector's DATA input. Per-digit enable masking and an inter-digit blanking interval suppress ghosting.

---
 rtl/display_scanner.sv | 180 ++++++++++++++++++
 tb/tb_display_scanner.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/display_scanner.sv
// ---------------------------------------------------------------------------
// display_scanner
//
// Time-multiplexing scan controller for an 8-digit seven-segment display.
// Each digit owns one slot of CLK_DIV cycles. A slot opens with BLANK_CYCLES
// cycles of all anodes off, which suppresses ghosting while the digit index
// and segment data settle. The rest of the slot drives one active-low anode.
// Disabled digits (digit_mask bit = 0) are skipped entirely. The display word
// is captured once per frame, so a frame never mixes nibbles of two words.
//
// Parameters:
//   CLK_DIV      - clock cycles per digit slot (blank + show), > BLANK_CYCLES
//   BLANK_CYCLES - all-anodes-off cycles at the start of each slot, >= 1
//
// Ports:
//   clk         in   1   system clock, rising edge
//   rst         in   1   synchronous active-high reset
//   en          in   1   scan enable; low blanks the display
//   data_in     in  32   display word, nibble k = digit k
//   digit_mask  in   8   bit k = 1 enables digit k
//   num         out  3   current digit index (nibble selector NUM)
//   an          out  8   anode enables, active-low, one-hot-low while showing
//   data_out    out 32   frame-latched display word (nibble selector DATA)
//   frame_start out  1   one-cycle pulse in the cycle data_out is (re)latched
// ---------------------------------------------------------------------------
module display_scanner #(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] data_in,
  input  logic [7:0]  digit_mask,
  output logic [2:0]  num,
  output logic [7:0]  an,
  output logic [31:0] data_out,
  output logic        frame_start
);

  // One counter spans the whole slot: BLANK uses 0..BLANK_CYCLES-1 and SHOW
  // continues from BLANK_CYCLES up to CLK_DIV-1.
  localparam int                CNT_W      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [7:0]        AN_OFF     = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_num;
  logic [7:0]       r_an;
  logic [31:0]      r_data;
  logic             r_fs;

  logic [2:0]       w_first_num;
  logic [2:0]       w_next_num;
  logic             w_wrap;
  logic             w_mask_any;

  // Lowest enabled digit; used when a fresh frame starts from IDLE.
  function automatic logic [2:0] lowest_digit(input logic [7:0] mask);
    logic [2:0] res;
    res = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (mask[k]) res = 3'(k);
    end
    return res;
  endfunction

  // First enabled digit after cur, searching cur+1 .. cur+8 modulo 8.
  // The final step (k = 8) lands on cur itself, so a single enabled digit
  // reselects itself.
  function automatic logic [2:0] next_digit(input logic [2:0] cur,
                                            input logic [7:0] mask);
    logic [2:0] idx;
    logic [2:0] res;
    logic       found;
    res   = cur;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = cur + 3'(k);
      if (!found && mask[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Active-low one-hot anode pattern for digit n.
  function automatic logic [7:0] anode_for(input logic [2:0] n);
    return ~(8'b1 << n);
  endfunction

  assign w_mask_any  = |digit_mask;
  assign w_first_num = lowest_digit(digit_mask);
  assign w_next_num  = next_digit(r_num, digit_mask);
  // Moving to an index at or below the current one means the scan wrapped
  // past digit 7, i.e. a new frame begins (self-reselect counts as a wrap).
  assign w_wrap      = (w_next_num <= r_num);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_num   <= 3'd0;
      r_an    <= AN_OFF;
      r_data  <= 32'd0;
      r_fs    <= 1'b0;
    end else begin
      r_fs <= 1'b0;
      if (!en) begin
        // Blank immediately; num and data_out keep their values so a
        // re-enable is the only thing that changes them.
        r_state <= IDLE;
        r_an    <= AN_OFF;
      end else begin
        case (r_state)
          IDLE: begin
            r_an <= AN_OFF;
            if (w_mask_any) begin
              r_num   <= w_first_num;
              r_data  <= data_in;
              r_fs    <= 1'b1;
              r_state <= BLANK;
              r_cnt   <= '0;
            end
          end

          BLANK: begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == BLANK_LAST) begin
              r_state <= SHOW;
              r_an    <= anode_for(r_num);
            end else begin
              r_an    <= AN_OFF;
            end
          end

          SHOW: begin
            if (r_cnt == LAST_CNT) begin
              // Slot end: the only point where digit_mask is consulted.
              r_an <= AN_OFF;
              if (!w_mask_any) begin
                r_state <= IDLE;
              end else begin
                r_num   <= w_next_num;
                r_state <= BLANK;
                r_cnt   <= '0;
                if (w_wrap) begin
                  r_data <= data_in;
                  r_fs   <= 1'b1;
                end
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end

          default: begin
            r_state <= IDLE;
            r_an    <= AN_OFF;
          end
        endcase
      end
    end
  end

  assign num         = r_num;
  assign an          = r_an;
  assign data_out    = r_data;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_display_scanner.sv
module tb_display_scanner;

  localparam int CLK_DIV = 10;
  localparam int BLANK   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] data_in;
  logic [7:0]  digit_mask;
  logic [2:0]  num;
  logic [7:0]  an;
  logic [31:0] data_out;
  logic        frame_start;

  int tests = 0;
  int fails = 0;

  display_scanner #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .digit_mask(digit_mask),
    .num(num), .an(an), .data_out(data_out), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Behavioural reference: a display that is either scanning or dark, a
  // position inside the current slot, the digit shown and the latched word.
  bit          m_act;
  int          m_pos;
  int          m_num;
  logic [31:0] m_data;
  bit          m_fs;

  task automatic model_step();
    int nxt;
    if (rst) begin
      m_act = 0; m_pos = 0; m_num = 0; m_data = 0; m_fs = 0;
      return;
    end
    m_fs = 0;
    if (!en) begin
      m_act = 0;
      return;
    end
    if (!m_act) begin
      if (digit_mask != 0) begin
        for (int k = 7; k >= 0; k--) if (digit_mask[k]) m_num = k;
        m_data = data_in; m_fs = 1; m_act = 1; m_pos = 0;
      end
    end else if (m_pos == CLK_DIV - 1) begin
      if (digit_mask == 0) begin
        m_act = 0;
      end else begin
        nxt = -1;
        for (int k = 1; k <= 8; k++)
          if (nxt < 0 && digit_mask[(m_num + k) % 8]) nxt = (m_num + k) % 8;
        if (nxt <= m_num) begin m_data = data_in; m_fs = 1; end
        m_num = nxt; m_pos = 0;
      end
    end else begin
      m_pos++;
    end
  endtask

  function automatic logic [7:0] model_an();
    if (m_act && m_pos >= BLANK) return ~(8'd1 << m_num);
    return 8'hFF;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One clock: update the reference on the edge, compare just after it.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model", {20'd0, num, an, data_out, frame_start},
                   {20'd0, 3'(m_num), model_an(), m_data, 1'(m_fs)});
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic [7:0]  mask;
    logic [31:0] din;
    int          n;
    logic [2:0]  num;
    logic [7:0]  an;
    logic [31:0] dout;
    logic        fs;
  } vec_t;

  vec_t tbl[$];

  task automatic measure_period(input logic [7:0] m, input int exp, input string name);
    int c;
    bit seen;
    digit_mask = m;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (frame_start) seen = 1;
    end
    c = 0;
    if (seen) begin
      seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
        tick();
        c++;
        if (frame_start) seen = 1;
      end
    end
    check(name, seen ? 64'(c) : 64'hFFFF_FFFF, 64'(exp));
  endtask

  initial begin
    tbl.push_back('{1'b0, 1'b1, 8'hFF, 32'h76543210,  1, 3'd0, 8'hFF, 32'h76543210, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'hFF, 32'h76543210,  1, 3'd0, 8'hFE, 32'h76543210, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'hFF, 32'h76543210,  7, 3'd0, 8'hFE, 32'h76543210, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'hFF, 32'h76543210,  1, 3'd1, 8'hFF, 32'h76543210, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'hFF, 32'h76543210,  2, 3'd1, 8'hFD, 32'h76543210, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'hFF, 32'h76543210,  8, 3'd2, 8'hFF, 32'h76543210, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'hFF, 32'h76543210, 52, 3'd7, 8'h7F, 32'h76543210, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'hFF, 32'h76543210,  8, 3'd0, 8'hFF, 32'h76543210, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 8'h05, 32'h76543210, 10, 3'd2, 8'hFF, 32'h76543210, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'h05, 32'h76543210,  2, 3'd2, 8'hFB, 32'h76543210, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'h05, 32'h76543210,  8, 3'd0, 8'hFF, 32'h76543210, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 8'h80, 32'h76543210, 10, 3'd7, 8'hFF, 32'h76543210, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'h80, 32'h76543210, 10, 3'd7, 8'hFF, 32'h76543210, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 8'h80, 32'h76543210,  2, 3'd7, 8'h7F, 32'h76543210, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'h80, 32'h76543210,  8, 3'd7, 8'hFF, 32'h76543210, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 8'hFF, 32'h76543210, 10, 3'd0, 8'hFF, 32'h76543210, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 8'hFF, 32'h76543210, 30, 3'd3, 8'hFF, 32'h76543210, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'hFF, 32'hDEADBEEF,  3, 3'd3, 8'hF7, 32'h76543210, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'hFF, 32'hDEADBEEF, 47, 3'd0, 8'hFF, 32'hDEADBEEF, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 8'hFF, 32'hDEADBEEF,  4, 3'd0, 8'hFE, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 8'hFF, 32'hDEADBEEF,  1, 3'd0, 8'hFF, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 8'hFF, 32'hDEADBEEF,  3, 3'd0, 8'hFF, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'h0C, 32'h12345678,  1, 3'd2, 8'hFF, 32'h12345678, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 8'h0C, 32'h12345678,  1, 3'd2, 8'hFF, 32'h12345678, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'h0C, 32'h12345678,  1, 3'd2, 8'hFB, 32'h12345678, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'h00, 32'h12345678,  7, 3'd2, 8'hFB, 32'h12345678, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'h00, 32'h12345678,  1, 3'd2, 8'hFF, 32'h12345678, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'h00, 32'hCAFEF00D, 20, 3'd2, 8'hFF, 32'h12345678, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'hFF, 32'hCAFEF00D,  1, 3'd0, 8'hFF, 32'hCAFEF00D, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 8'hFF, 32'hCAFEF00D,  3, 3'd0, 8'hFE, 32'hCAFEF00D, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'hFF, 32'hCAFEF00D,  1, 3'd0, 8'hFF, 32'h00000000, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'hFF, 32'hCAFEF00D,  1, 3'd0, 8'hFF, 32'hCAFEF00D, 1'b1});

    m_act = 0; m_pos = 0; m_num = 0; m_data = 0; m_fs = 0;
    rst = 1'b1; en = 1'b1; digit_mask = 8'hFF; data_in = 32'h76543210;

    // Reset held with en=1: outputs stay at reset values.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_num", 64'(num), 64'd0);
      check("rst_an", 64'(an), 64'hFF);
      check("rst_dout", 64'(data_out), 64'd0);
      check("rst_fs", 64'(frame_start), 64'd0);
    end

    // First edge after release starts the frame.
    rst = 1'b0;
    tick();
    check("first_fs", 64'(frame_start), 64'd1);
    check("first_dout", 64'(data_out), 64'h76543210);
    check("first_an", 64'(an), 64'hFF);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; en = tbl[i].en; digit_mask = tbl[i].mask; data_in = tbl[i].din;
      repeat (tbl[i].n) tick();
      check($sformatf("vec%0d_num", i), 64'(num), 64'(tbl[i].num));
      check($sformatf("vec%0d_an", i), 64'(an), 64'(tbl[i].an));
      check($sformatf("vec%0d_dout", i), 64'(data_out), 64'(tbl[i].dout));
      check($sformatf("vec%0d_fs", i), 64'(frame_start), 64'(tbl[i].fs));
    end

    // Frame period for several masks.
    rst = 1'b0; en = 1'b1;
    measure_period(8'h05, 20, "period_05");
    measure_period(8'hFF, 80, "period_FF");
    measure_period(8'h80, 10, "period_80");

    // Randomized traffic against the reference.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 3))
          0:       digit_mask = 8'h00;
          1:       digit_mask = 8'd1 << $urandom_range(0, 7);
          default: digit_mask = 8'($urandom);
        endcase
      end
      if ($urandom_range(0, 6) == 0) data_in = $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
